// File: rtl/divide_shift_sub.sv
// rtl/divide_shift_sub.sv - sequential restoring (shift-subtract) unsigned divider
//
// Purpose: divides an N-bit dividend A by an N-bit divisor B, one quotient bit per
// clock, using the same in_en / done start-finish handshake as the shift-add multiplier.
//
// Ports:
//   clk    in   1  system clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   in_en  in   1  start request, sampled while idle
//   A      in   N  dividend, captured on the start edge
//   B      in   N  divisor, captured on the start edge
//   busy   out  1  high while a division is in progress
//   done   out  1  one-cycle pulse, Q/R valid from this cycle on
//   Q      out  N  quotient, held until the next done
//   R      out  N  remainder, held until the next done
//   dbz    out  1  divide-by-zero flag, updated at every done (only with DIVIDE_DBZ_EN)
//
// Optional feature macro: DIVIDE_DBZ_EN (adds dbz and a one-edge divide-by-zero path).

module divide_shift_sub #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_en,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R
`ifdef DIVIDE_DBZ_EN
    ,
    output logic         dbz
`endif
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [N:0]    rem_r, rem_n;
    logic [N-1:0]  quo_r, quo_n;
    logic [N-1:0]  div_r, div_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          busy_n, done_n;
    logic [N-1:0]  q_n, r_n;

    logic [N:0]    t;
    logic          ge;
    logic [N:0]    rem_step;
    logic [N-1:0]  quo_step;
    logic          dbz_start;

`ifdef DIVIDE_DBZ_EN
    logic dbz_n;
    assign dbz_start = (B == '0);
`else
    assign dbz_start = 1'b0;
`endif

    // Shift the next dividend bit into the partial remainder. A set rem_r[N] would
    // mean the shifted value is at least 2^(N+1), which always exceeds the divisor.
    assign t        = {rem_r[N-1:0], quo_r[N-1]};
    assign ge       = rem_r[N] | (t >= {1'b0, div_r});
    assign rem_step = ge ? (t - {1'b0, div_r}) : t;
    assign quo_step = {quo_r[N-2:0], ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rem_r <= '0;
            quo_r <= '0;
            div_r <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            Q     <= '0;
            R     <= '0;
`ifdef DIVIDE_DBZ_EN
            dbz   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            rem_r <= rem_n;
            quo_r <= quo_n;
            div_r <= div_n;
            cnt   <= cnt_n;
            busy  <= busy_n;
            done  <= done_n;
            Q     <= q_n;
            R     <= r_n;
`ifdef DIVIDE_DBZ_EN
            dbz   <= dbz_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem_r;
        quo_n   = quo_r;
        div_n   = div_r;
        cnt_n   = cnt;
        busy_n  = busy;
        done_n  = 1'b0;
        q_n     = Q;
        r_n     = R;
`ifdef DIVIDE_DBZ_EN
        dbz_n   = dbz;
`endif
        case (state)
            IDLE: begin
                if (in_en) begin
                    if (dbz_start) begin
                        // Divide by zero short-cut: finish on the start edge itself.
                        q_n    = '1;
                        r_n    = A;
                        done_n = 1'b1;
                        busy_n = 1'b0;
`ifdef DIVIDE_DBZ_EN
                        dbz_n  = 1'b1;
`endif
                    end else begin
                        quo_n   = A;
                        div_n   = B;
                        rem_n   = '0;
                        cnt_n   = '0;
                        busy_n  = 1'b1;
                        state_n = CALC;
                    end
                end
            end
            CALC: begin
                cnt_n = cnt + 1'b1;
                if (cnt == CW'(N - 1)) begin
                    // Last iteration lands directly in the result registers.
                    q_n     = quo_step;
                    r_n     = rem_step[N-1:0];
                    done_n  = 1'b1;
                    busy_n  = 1'b0;
                    state_n = IDLE;
`ifdef DIVIDE_DBZ_EN
                    dbz_n   = 1'b0;
`endif
                end else begin
                    rem_n = rem_step;
                    quo_n = quo_step;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_divide_shift_sub.sv
// tb/tb_divide_shift_sub.sv - self-checking bench for divide_shift_sub

module tb_divide_shift_sub;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         in_en;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] Q;
    logic [N-1:0] R;
`ifdef DIVIDE_DBZ_EN
    logic         dbz;
`endif

    int n_cmp = 0;
    int n_err = 0;

    divide_shift_sub #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .in_en (in_en),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R)
`ifdef DIVIDE_DBZ_EN
        ,
        .dbz   (dbz)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division, with the all-ones / pass-through rule for B=0.
    function automatic int ref_q(input int a, input int b);
        return (b == 0) ? (1 << N) - 1 : a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        return (b == 0) ? a : a % b;
    endfunction

    function automatic int ref_lat(input int b);
`ifdef DIVIDE_DBZ_EN
        return (b == 0) ? 0 : N;
`else
        return (b == 0) ? N : N;
`endif
    endfunction

    // One isolated operation: latency (edges after the start edge), busy cycles, results,
    // single-cycle done pulse and held results.
    task automatic run_op(input int a, input int b, input string tag);
        int lat;
        int busy_cnt;
        @(negedge clk);
        A = a[N-1:0];
        B = b[N-1:0];
        in_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_en = 1'b0;
        lat = 0;
        busy_cnt = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, lat, ref_lat(b));
        check({tag, "_busy"}, busy_cnt, ref_lat(b));
        check({tag, "_q"}, int'(Q), ref_q(a, b));
        check({tag, "_r"}, int'(R), ref_r(a, b));
`ifdef DIVIDE_DBZ_EN
        check({tag, "_dbz"}, int'(dbz), (b == 0) ? 1 : 0);
`endif
        @(negedge clk);
        check({tag, "_pulse"}, int'(done), 0);
        check({tag, "_hold"}, int'(Q), ref_q(a, b));
    endtask

    initial begin
        int pulses;
        int q_first;
        int r_first;
        int nd;
        int d_t[2];
        int d_q[2];
        int d_r[2];
        int a;
        int b;

        rst_n = 1'b0;
        in_en = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(Q), 0);
        check("rst_r", int'(R), 0);
        rst_n = 1'b1;

        run_op(200, 7, "d200_7");
        run_op(255, 1, "d255_1");
        run_op(5, 9, "d5_9");
        run_op(0, 3, "d0_3");
        run_op(173, 0, "d173_0");
        run_op(10, 3, "d10_3");
        run_op(255, 255, "d255_255");
        run_op(254, 255, "d254_255");
        run_op(255, 128, "d255_128");

        // in_en pulsed while busy must be ignored.
        @(negedge clk);
        A = 8'd200;
        B = 8'd7;
        in_en = 1'b1;
        @(posedge clk);
        pulses = 0;
        q_first = -1;
        r_first = -1;
        for (int i = 0; i < 2 * N + 4; i++) begin
            @(negedge clk);
            if (i == 0) in_en = 1'b0;
            if (i == 2) begin
                A = 8'd50;
                B = 8'd5;
                in_en = 1'b1;
            end
            if (i == 3) in_en = 1'b0;
            if (done) begin
                pulses++;
                if (q_first < 0) begin
                    check("ign_done_at", i, N);
                    q_first = int'(Q);
                    r_first = int'(R);
                end
            end
        end
        check("ign_pulses", pulses, 1);
        check("ign_q", q_first, 28);
        check("ign_r", r_first, 4);

        // Back-to-back with in_en held high.
        @(negedge clk);
        A = 8'd100;
        B = 8'd10;
        in_en = 1'b1;
        @(posedge clk);
        nd = 0;
        for (int i = 0; i < 3 * N + 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                A = 8'd99;
                B = 8'd4;
            end
            if (nd == 1 && i == d_t[0] + 1) in_en = 1'b0;
            if (done) begin
                if (nd < 2) begin
                    d_t[nd] = i;
                    d_q[nd] = int'(Q);
                    d_r[nd] = int'(R);
                end
                nd++;
            end
        end
        check("b2b_count", nd, 2);
        check("b2b_gap", d_t[1] - d_t[0], N + 1);
        check("b2b_q0", d_q[0], 10);
        check("b2b_r0", d_r[0], 0);
        check("b2b_q1", d_q[1], 24);
        check("b2b_r1", d_r[1], 3);

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        A = 8'd200;
        B = 8'd7;
        in_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_busy_pre", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", int'(busy), 0);
        check("mid_done", int'(done), 0);
        check("mid_q", int'(Q), 0);
        check("mid_r", int'(R), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("mid_no_done", pulses, 0);
        run_op(200, 7, "post_rst");

        // Randomized operands against the arithmetic reference.
        for (int k = 0; k < 30; k++) begin
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run_op(a, b, $sformatf("rnd%0d_%0d_%0d", k, a, b));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
